// File: rtl/md_unit_ctrl.sv
// Multiply/divide controller for the EX stage.
// Owns the HI/LO registers. A MULT/MULTU/DIV/DIVU result is computed when the
// command is accepted. It is held in a pending register and committed to HI/LO
// after a fixed latency. While the result is held, busy stalls the hazard unit.
module md_unit_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] counter;
    logic [31:0]   pending_hi;
    logic [31:0]   pending_lo;
    logic          pending_dz;

    logic          is_mul;
    logic          is_div;
    logic [63:0]   a_ext;
    logic [63:0]   b_ext;
    logic [63:0]   prod;
    logic          a_neg;
    logic          b_neg;
    logic [31:0]   a_mag;
    logic [31:0]   b_mag;
    logic [31:0]   divisor;
    logic [31:0]   q_mag;
    logic [31:0]   r_mag;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;

    // Compute the 64-bit MULT/DIV result from the operands presented this cycle.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through this block leaves a latch.
        is_mul  = (md_op == OP_MULT) || (md_op == OP_MULTU);
        is_div  = (md_op == OP_DIV)  || (md_op == OP_DIVU);
        res_hi  = '0;
        res_lo  = '0;

        // Sign- or zero-extend to 64 bits. The low 64 bits of the product are
        // then correct for both MULT and MULTU.
        a_ext   = (md_op == OP_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
        b_ext   = (md_op == OP_MULT) ? {{32{b[31]}}, b} : {32'd0, b};
        prod    = a_ext * b_ext;

        // Signed divide works on magnitudes and then fixes the signs. The
        // quotient takes the XOR of the operand signs. The remainder takes the
        // sign of the dividend. 0x80000000 / -1 wraps back to 0x80000000.
        a_neg   = (md_op == OP_DIV) && a[31];
        b_neg   = (md_op == OP_DIV) && b[31];
        a_mag   = a_neg ? -a : a;
        b_mag   = b_neg ? -b : b;
        divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;

        if (is_mul) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else if (is_div) begin
            res_hi = a_neg ? -r_mag : r_mag;
            res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
        end
    end

    // Controller FSM: accept commands in IDLE and count down in RUN. HI/LO are
    // committed on the last busy edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            counter    <= '0;
            // NOTE: the pending result is cleared too, so a reset mid-operation
            //       leaves nothing behind that a later commit could pick up.
            pending_hi <= '0;
            pending_lo <= '0;
            pending_dz <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            //       every register here samples pre-edge values.
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mul || is_div) begin
                            pending_hi <= res_hi;
                            pending_lo <= res_lo;
                            pending_dz <= is_div && (b == 32'd0);
                            counter    <= is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
                            busy       <= 1'b1;
                            state      <= RUN;
                        end else if (md_op == OP_MTHI) begin
                            hi <= a;
                        end else if (md_op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                RUN: begin
                    // Commands arriving here are dropped. The hazard unit
                    // prevents them, so none are expected.
                    counter <= counter - CW'(1);
                    if (counter == CW'(1)) begin
                        if (!pending_dz) begin
                            hi <= pending_hi;
                            lo <= pending_lo;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl. The stimulus process pushes the expected
// architectural HI/LO and busy duration when a command is accepted. A monitor
// on the falling edge pops and compares when the command completes.
module tb_md_unit_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl_hi = '0;
    logic [31:0] mdl_lo = '0;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural effect of one accepted command
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                                   input logic [31:0] oh, input logic [31:0] ol);
        exp_t        e;
        longint      sa, sb, sq, sr;
        logic [63:0] up;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        e.old_hi = oh;
        e.old_lo = ol;
        e.exp_hi = oh;
        e.exp_lo = ol;
        e.lat    = 0;
        case (op)
            3'd1: begin
                sq = sa * sb;
                e.exp_hi = sq[63:32];
                e.exp_lo = sq[31:0];
                e.lat = MULT_LAT;
            end
            3'd2: begin
                up = {32'd0, av} * {32'd0, bv};
                e.exp_hi = up[63:32];
                e.exp_lo = up[31:0];
                e.lat = MULT_LAT;
            end
            3'd3: begin
                if (bv != 0) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    e.exp_lo = sq[31:0];
                    e.exp_hi = sr[31:0];
                end
                e.lat = DIV_LAT;
            end
            3'd4: begin
                if (bv != 0) begin
                    e.exp_lo = av / bv;
                    e.exp_hi = av % bv;
                end
                e.lat = DIV_LAT;
            end
            3'd5: e.exp_hi = av;
            3'd6: e.exp_lo = av;
            default: ;
        endcase
        return e;
    endfunction

    // Monitor: counts busy cycles for the head command and checks HI/LO hold and commit
    int cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!mon_en) begin
            cnt = 0;
        end else if (sb_q.size() == 0) begin
            cnt = 0;
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_hi", hi, mdl_hi);
            check("idle_lo", lo, mdl_lo);
        end else begin
            e = sb_q[0];
            if (busy) begin
                cnt++;
                check("hold_hi", hi, e.old_hi);
                check("hold_lo", lo, e.old_lo);
            end else begin
                check("latency", 32'(cnt), 32'(e.lat));
                check("commit_hi", hi, e.exp_hi);
                check("commit_lo", lo, e.exp_lo);
                mdl_hi = e.exp_hi;
                mdl_lo = e.exp_lo;
                void'(sb_q.pop_front());
                cnt = 0;
            end
        end
    end

    // Drive one command (called between a falling and the next rising edge)
    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        md_op = op; a = av; b = bv; start = 1'b1;
        @(posedge clk);
        if (op >= 3'd1 && op <= 3'd6) sb_q.push_back(model(op, av, bv, mdl_hi, mdl_lo));
        #1;
        start = 1'b0; md_op = 3'd0;
    endtask

    // Drive a command while busy; it must have no effect
    task automatic issue_ignored(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        md_op = op; a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; md_op = 3'd0;
    endtask

    // Wait until the scoreboard drains; returns just after a falling edge
    task automatic wait_done();
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) break;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd0;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; md_op = 3'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        #1;

        // Preload HI/LO so that the reset below visibly clears them
        issue(3'd5, 32'h0000_1234, 32'd0);
        issue(3'd6, 32'h0000_5678, 32'd0);
        wait_done();

        // Reset mid-operation: asynchronous clear, no later commit
        mon_en = 1'b0;
        issue_ignored(3'd1, 32'd5, 32'd7);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        mdl_hi = '0;
        mdl_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("postrst_busy", 32'(busy), 32'd0);
            check("postrst_hi", hi, 32'd0);
            check("postrst_lo", lo, 32'd0);
        end
        mon_en = 1'b1;
        #1;

        // Directed arithmetic cases
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);        wait_done();
        issue(3'd2, 32'hFFFF_FFFE, 32'd3);        wait_done();
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);        wait_done();
        issue(3'd4, 32'd7, 32'd2);                wait_done();
        issue(3'd5, 32'h11, 32'd0);               wait_done();
        issue(3'd6, 32'h22, 32'd0);               wait_done();
        issue(3'd3, 32'd5, 32'd0);                wait_done();
        issue(3'd4, 32'd9, 32'd0);                wait_done();
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
        issue(3'd5, 32'hDEAD_BEEF, 32'd0);        wait_done();
        issue(3'd0, 32'h1, 32'h2);                wait_done();
        issue(3'd7, 32'h1, 32'h2);                wait_done();

        // Commands while busy are ignored
        issue(3'd1, 32'd6, 32'd7);
        issue_ignored(3'd6, 32'h5555_5555, 32'd0);
        issue_ignored(3'd5, 32'hAAAA_AAAA, 32'd0);
        issue_ignored(3'd3, 32'd100, 32'd3);
        wait_done();

        // Back-to-back: next command in the first idle cycle
        issue(3'd1, 32'd3, 32'd4);                wait_done();
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
        issue(3'd4, 32'hFFFF_FFFF, 32'd16);       wait_done();

        // Randomised commands
        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            issue(op, rnd_operand(), rnd_operand());
            if (op >= 3'd1 && op <= 3'd4 && $urandom_range(0, 3) == 0)
                issue_ignored(3'($urandom_range(1, 6)), $urandom, $urandom);
            wait_done();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            #1;
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Multi-cycle multiply/divide controller for the EX stage of the pipelined MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands and holds the operation for a fixed latency.
- Owns the HI/LO registers and drives a busy flag that the hazard unit uses to stall MFHI/MFLO and further MD instructions.
- Signed vs unsigned handling mirrors the ExtOp convention: op selects a sign-extended or a zero-extended interpretation of the operands.

Parameters:
- MULT_LAT, 5, cycles busy stays high for MULT/MULTU (≥1)
- DIV_LAT, 10, cycles busy stays high for DIV/DIVU (≥1)

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  command valid, sampled on the rising edge
- md_op  input  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
- a  input  32  rs operand
- b  input  32  rt operand
- busy  output  1  an operation is in flight
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (rst_n=0, asynchronous): busy=0, hi=0, lo=0, counter=0, pending result cleared. Takes effect immediately, even mid-operation; the in-flight result is discarded.
- States: IDLE (busy=0) and RUN (busy=1).
- IDLE, edge with start=1 and md_op in 1..4:
  - Compute the 64-bit result from a and b at this edge and latch it into pending_hi/pending_lo.
  - Load counter with MULT_LAT or DIV_LAT and enter RUN.
- IDLE, edge with start=1 and md_op=5 or 6:
  - Write a into hi (5) or lo (6) at this edge.
  - busy stays 0; the new value is visible the next cycle.
- IDLE, start=1 with md_op 0 or 7: no effect.
- RUN:
  - Each edge decrements counter.
  - On the edge where counter==1: hi<=pending_hi, lo<=pending_lo, busy<=0, return to IDLE.
  - busy is therefore high for exactly LAT cycles. HI/LO keep their old values throughout RUN.
- start while busy=1: ignored, including MTHI/MTLO. The hazard unit guarantees this never happens; the bench checks that it is ignored.
- Back-to-back: start may be asserted in the first IDLE cycle after busy falls, and is accepted.
- MULT: signed 32x32 to 64, {hi,lo} = $signed(a) * $signed(b).
- MULTU: same as MULT with both operands zero-extended.
- DIV: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
- DIV overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (b=0, DIV or DIVU): full latency still runs and busy behaves normally; hi and lo are left unchanged at commit.
- No combinational path from inputs to outputs; hi, lo and busy are all registered.

Test Plan:
- Reset mid-op: MULT started, rst_n pulled low at cycle 2 → busy=0, hi=0, lo=0 immediately (asynchronously); no later commit occurs.
- MULT with a=0xFFFFFFFE (-2), b=3 → busy high for exactly 5 cycles; at the falling edge of busy, hi=0xFFFFFFFF, lo=0xFFFFFFFA. HI/LO hold their old values during busy.
- MULTU with a=0xFFFFFFFE, b=3 → hi=0x00000002, lo=0xFFFFFFFA after 5 cycles.
- DIV a=-7 (0xFFFFFFF9), b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- DIV by zero (preload hi=0x11, lo=0x22), then DIV 0x80000000 / 0xFFFFFFFF:
  - Divide by zero → busy for 10 cycles, then hi=0x11, lo=0x22 unchanged.
  - Overflow case → lo=0x80000000, hi=0.
- MTHI a=0xDEADBEEF in IDLE → hi=0xDEADBEEF next cycle, busy never rises.
- MTLO issued during busy → ignored; lo takes the MULT result at commit.
- Next MULT started the cycle after busy falls → accepted.
